// File: rtl/mem_master_pkg.sv
// Shared types and default widths for the mem_master burst initiator.
// State encodings are plain constants so legacy code can compare against them directly.
package mem_master_pkg;

  localparam int DEF_ADDR_W      = 4;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_LEN_W       = 4;
  localparam int DEF_TIMEOUT_CYC = 8;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WR       = 2'd1;
  localparam logic [1:0] ST_RD_ISSUE = 2'd2;
  localparam logic [1:0] ST_RD_WAIT  = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = ST_IDLE,
    WR       = ST_WR,
    RD_ISSUE = ST_RD_ISSUE,
    RD_WAIT  = ST_RD_WAIT
  } state_e;

endpackage

// File: rtl/mem_master_wdog.sv
// Loadable down-counter with an expire flag; guards each read beat's wait for memory data.
// Only compiled into the design when MEM_MASTER_TIMEOUT_EN is defined.
`ifdef MEM_MASTER_TIMEOUT_EN
module mem_master_wdog #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             expired
);

  logic [CNT_W-1:0] cnt;

  // Holds at zero once expired; load always wins so a fresh beat restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule
`endif

// File: rtl/mem_master.sv
// Burst initiator for the single-port memory: one burst at a time, one read outstanding.
// Define MEM_MASTER_TIMEOUT_EN to bound each read beat's wait and report o_rsp_err.
module mem_master
  import mem_master_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int LEN_W       = DEF_LEN_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [LEN_W-1:0]  i_req_len,
  input  logic              i_wvalid,
  output logic              o_wready,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic              o_rsp_err,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_data,
  output logic              o_mem_we,
  input  logic [DATA_W-1:0] i_mem_data,
  input  logic              i_mem_valid
);

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("mem_master: TIMEOUT_CYC must be at least 1");
  end

  state_e            state;
  state_e            state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  cnt;
  logic              last;
  logic              req_fire;
  logic              wr_fire;
  logic              rd_hit;
  logic              rd_to;

  assign last     = (cnt == len);
  assign req_fire = (state == IDLE) && i_req_valid && o_req_ready;
  assign wr_fire  = (state == WR) && i_wvalid && o_wready;
  assign rd_hit   = (state == RD_WAIT) && i_mem_valid;
  assign o_busy   = (state != IDLE);

`ifdef MEM_MASTER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic expired;

  // Loaded during RD_ISSUE so it reaches zero on the TIMEOUT_CYC-th RD_WAIT cycle.
  mem_master_wdog #(
    .CNT_W (TO_W)
  ) u_wdog (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .load     (state == RD_ISSUE),
    .load_val (TO_W'(TIMEOUT_CYC - 1)),
    .en       (state == RD_WAIT),
    .expired  (expired)
  );

  assign rd_to = (state == RD_WAIT) && !i_mem_valid && expired;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rsp_err <= 1'b0;
    end else begin
      o_rsp_err <= rd_to;
    end
  end
`else
  assign rd_to     = 1'b0;
  assign o_rsp_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_fire) begin
          state_nxt = i_req_we ? WR : RD_ISSUE;
        end
      end
      WR: begin
        if (wr_fire && last) begin
          state_nxt = IDLE;
        end
      end
      RD_ISSUE: begin
        state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        if (rd_hit) begin
          state_nxt = last ? IDLE : RD_ISSUE;
        end else if (rd_to) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Read addresses are registered on entry to RD_ISSUE, so the memory sees them
  // during RD_ISSUE and any i_mem_valid seen in RD_WAIT belongs to that address.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      addr        <= '0;
      len         <= '0;
      cnt         <= '0;
      o_req_ready <= 1'b0;
      o_wready    <= 1'b0;
      o_rsp_valid <= 1'b0;
      o_rsp_data  <= '0;
      o_mem_addr  <= '0;
      o_mem_data  <= '0;
      o_mem_we    <= 1'b0;
    end else begin
      state       <= state_nxt;
      o_req_ready <= (state_nxt == IDLE);
      o_wready    <= (state_nxt == WR);
      o_mem_we    <= 1'b0;
      o_rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_fire) begin
            addr <= i_req_addr;
            len  <= i_req_len;
            cnt  <= '0;
            if (!i_req_we) begin
              o_mem_addr <= i_req_addr;
            end
          end
        end
        WR: begin
          if (wr_fire) begin
            o_mem_addr <= addr;
            o_mem_data <= i_wdata;
            o_mem_we   <= 1'b1;
            addr       <= addr + 1'b1;
            cnt        <= cnt + 1'b1;
          end
        end
        RD_WAIT: begin
          if (rd_hit) begin
            o_rsp_valid <= 1'b1;
            o_rsp_data  <= i_mem_data;
            if (!last) begin
              addr       <= addr + 1'b1;
              cnt        <= cnt + 1'b1;
              o_mem_addr <= addr + 1'b1;
            end
          end else if (rd_to) begin
            o_rsp_valid <= 1'b1;
            o_rsp_data  <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_master.sv
// Directed bench for mem_master: burst table plus reset, spurious-valid and timeout sequences.
module tb_mem_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [3:0]  req_addr = 4'h0;
  logic [3:0]  req_len = 4'h0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [31:0] wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic [3:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic        mem_valid;
  logic        mem_valid_in;
  logic        mem_en = 1'b1;
  logic        spur = 1'b0;
  logic [31:0] mem [16];

  always #5 clk = ~clk;

  mem_master dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_we    (req_we),
    .i_req_addr  (req_addr),
    .i_req_len   (req_len),
    .i_wvalid    (wvalid),
    .o_wready    (wready),
    .i_wdata     (wdata),
    .o_rsp_valid (rsp_valid),
    .o_rsp_data  (rsp_data),
    .o_rsp_err   (rsp_err),
    .o_busy      (busy),
    .o_mem_addr  (mem_addr),
    .o_mem_data  (mem_wdata),
    .o_mem_we    (mem_we),
    .i_mem_data  (mem_rdata),
    .i_mem_valid (mem_valid_in)
  );

  // Memory model: one-cycle read latency, valid on every non-write cycle while enabled.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
    mem_valid <= mem_en && !mem_we;
  end
  assign mem_valid_in = mem_valid | spur;

  typedef struct { logic [3:0] a; logic [31:0] d; int c; } wev_t;
  typedef struct { logic [31:0] d; logic e; int c; } rev_t;
  typedef struct { logic we; logic [3:0] addr; logic [3:0] len; logic [31:0] base; } vec_t;

  wev_t wq[$];
  rev_t rq[$];
  wev_t wev;
  rev_t rev;
  vec_t vec [7];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we) begin
      wev.a = mem_addr; wev.d = mem_wdata; wev.c = cyc;
      wq.push_back(wev);
    end
    if (rsp_valid) begin
      rev.d = rsp_data; rev.e = rsp_err; rev.c = cyc;
      rq.push_back(rev);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic start_req(input logic we, input logic [3:0] addr, input logic [3:0] len,
                           output int c0);
    int t;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_len = len;
    t = 0;
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    c0 = cyc;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("busy_drops", 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  task automatic run_burst(input vec_t v);
    int c0;
    logic [3:0] ea;
    wq.delete();
    rq.delete();
    start_req(v.we, v.addr, v.len, c0);
    if (v.we) begin
      for (int i = 0; i <= int'(v.len); i++) begin
        wvalid = 1'b1;
        wdata  = v.base + 32'(i);
        chk("wready", 32'(wready), 32'd1);
        @(posedge clk);
        @(negedge clk);
      end
      wvalid = 1'b0;
    end
    wait_idle();
    chk("req_ready_after", 32'(req_ready), 32'd1);
    if (v.we) begin
      chk("wr_beats", 32'(wq.size()), 32'(v.len) + 32'd1);
      chk("wr_no_rsp", 32'(rq.size()), 32'd0);
      for (int i = 0; i < wq.size() && i <= int'(v.len); i++) begin
        ea = v.addr + 4'(i);
        chk("wr_addr", 32'(wq[i].a), 32'(ea));
        chk("wr_data", wq[i].d, v.base + 32'(i));
        chk("wr_cycle", 32'(wq[i].c), 32'(c0 + 1 + i));
      end
    end else begin
      chk("rd_beats", 32'(rq.size()), 32'(v.len) + 32'd1);
      chk("rd_no_write", 32'(wq.size()), 32'd0);
      for (int i = 0; i < rq.size() && i <= int'(v.len); i++) begin
        chk("rd_data", rq[i].d, v.base + 32'(i));
        chk("rd_err", 32'(rq[i].e), 32'd0);
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_wready"},    32'(wready),    32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_data"},  rsp_data,       32'd0);
    chk({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
    chk({tag, "_mem_data"},  mem_wdata,      32'd0);
    chk({tag, "_mem_we"},    32'(mem_we),    32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int c0;
    vec[0] = '{we: 1'b1, addr: 4'h3, len: 4'h3, base: 32'h000000A0};
    vec[1] = '{we: 1'b0, addr: 4'h3, len: 4'h3, base: 32'h000000A0};
    vec[2] = '{we: 1'b1, addr: 4'hF, len: 4'h1, base: 32'h000000B0};
    vec[3] = '{we: 1'b0, addr: 4'hF, len: 4'h1, base: 32'h000000B0};
    vec[4] = '{we: 1'b1, addr: 4'h8, len: 4'h0, base: 32'h000000C5};
    vec[5] = '{we: 1'b0, addr: 4'h8, len: 4'h0, base: 32'h000000C5};
    vec[6] = '{we: 1'b0, addr: 4'h4, len: 4'h1, base: 32'h000000A1};

    repeat (3) @(negedge clk);
    chk_all_zero("por");
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_por", 32'(req_ready), 32'd1);

    for (int k = 0; k < 4; k++) run_burst(vec[k]);

    spur = 1'b1;
    rq.delete();
    repeat (10) @(negedge clk);
    chk("spur_idle_no_rsp", 32'(rq.size()), 32'd0);
    run_burst(vec[4]);
    spur = 1'b0;
    for (int k = 5; k < 7; k++) run_burst(vec[k]);

    // Reset while a read is stalled waiting on memory.
    mem_en = 1'b0;
    rq.delete();
    start_req(1'b0, 4'h3, 4'h3, c0);
    repeat (5) @(negedge clk);
    chk("stall_busy", 32'(busy), 32'd1);
    chk("stall_no_rsp", 32'(rq.size()), 32'd0);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mem_en = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(req_ready), 32'd1);
    chk("idle_after_rst", 32'(busy), 32'd0);
    repeat (10) @(negedge clk);
    chk("abort_no_rsp", 32'(rq.size()), 32'd0);

`ifdef MEM_MASTER_TIMEOUT_EN
    mem_en = 1'b0;
    rq.delete();
    start_req(1'b0, 4'h2, 4'h2, c0);
    wait_idle();
    chk("to_rsp_count", 32'(rq.size()), 32'd1);
    if (rq.size() > 0) begin
      chk("to_err", 32'(rq[0].e), 32'd1);
      chk("to_data", rq[0].d, 32'd0);
      chk("to_cycle", 32'(rq[0].c), 32'(c0 + 9));
    end
    chk("to_ready", 32'(req_ready), 32'd1);
    mem_en = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
